// File: rtl/apb3_ctrl_pkg.sv
// Shared types and width helpers for the APB3 round-robin master and its arbiter.
package apb3_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS
  } apb_st_t;

  // Counter width able to hold 0..to_cycles.
  function automatic int to_width(input int to_cycles);
    return $clog2(to_cycles + 1);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping to 0.
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    idx,
  output logic             valid
);

  logic [IW-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = IW'((int'(ptr) + i) % N_REQ);
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/apb3_rr_master.sv
// Shares one APB3 master port among N_REQ requesters with round-robin grant,
// SETUP/ACCESS sequencing and a PREADY timeout that forces an error completion.
module apb3_rr_master
  import apb3_ctrl_pkg::*;
#(
  parameter int N_REQ     = 2,
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int TO_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ-1:0]    req_write,
  input  logic [N_REQ*AW-1:0] req_addr,
  input  logic [N_REQ*DW-1:0] req_wdata,
  output logic [N_REQ-1:0]    ack,
  output logic [DW-1:0]       rsp_rdata,
  output logic                rsp_err,
  output logic                busy,
  output logic [AW-1:0]       m_addr,
  output logic                m_sel,
  output logic                m_enable,
  output logic                m_write,
  output logic [DW-1:0]       m_wdata,
  input  logic [DW-1:0]       m_rdata,
  input  logic                m_ready,
  input  logic                m_slverr
);

  localparam int IW   = idx_width(N_REQ);
  localparam int TO_W = to_width(TO_CYCLES);

  apb_st_t           state_q, state_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic [DW-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              busy_q, busy_d;
  logic [AW-1:0]     m_addr_q, m_addr_d;
  logic              m_sel_q, m_sel_d;
  logic              m_enable_q, m_enable_d;
  logic              m_write_q, m_write_d;
  logic [DW-1:0]     m_wdata_q, m_wdata_d;

  logic [AW-1:0]     addr_arr  [N_REQ];
  logic [DW-1:0]     wdata_arr [N_REQ];
  logic [N_REQ-1:0]  arb_gnt;
  logic [IW-1:0]     arb_idx;
  logic              arb_valid;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*AW +: AW];
    assign wdata_arr[g] = req_wdata[g*DW +: DW];
  end

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_arb (
    .req   (req),
    .ptr   (ptr_q),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    ack_d       = '0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    m_addr_d    = m_addr_q;
    m_sel_d     = m_sel_q;
    m_enable_d  = m_enable_q;
    m_write_d   = m_write_q;
    m_wdata_d   = m_wdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          grant_d    = arb_gnt;
          ptr_d      = (arb_idx == IW'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
          m_addr_d   = addr_arr[arb_idx];
          m_wdata_d  = wdata_arr[arb_idx];
          m_write_d  = req_write[arb_idx];
          m_sel_d    = 1'b1;
          m_enable_d = 1'b0;
          state_d    = ST_SETUP;
        end
      end

      ST_SETUP: begin
        m_enable_d = 1'b1;
        cnt_d      = '0;
        state_d    = ST_ACCESS;
      end

      ST_ACCESS: begin
        // A ready slave wins over an expiring timeout in the same cycle.
        if (m_ready) begin
          ack_d       = grant_q;
          rsp_rdata_d = m_write_q ? '0 : m_rdata;
          rsp_err_d   = m_slverr;
          m_sel_d     = 1'b0;
          m_enable_d  = 1'b0;
          m_write_d   = 1'b0;
          state_d     = ST_IDLE;
        end else if (cnt_q == TO_W'(TO_CYCLES - 1)) begin
          ack_d      = grant_q;
          rsp_err_d  = 1'b1;
          m_sel_d    = 1'b0;
          m_enable_d = 1'b0;
          m_write_d  = 1'b0;
          state_d    = ST_IDLE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        m_sel_d    = 1'b0;
        m_enable_d = 1'b0;
        m_write_d  = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      ack_q       <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      m_addr_q    <= '0;
      m_sel_q     <= 1'b0;
      m_enable_q  <= 1'b0;
      m_write_q   <= 1'b0;
      m_wdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      ack_q       <= ack_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
      m_addr_q    <= m_addr_d;
      m_sel_q     <= m_sel_d;
      m_enable_q  <= m_enable_d;
      m_write_q   <= m_write_d;
      m_wdata_q   <= m_wdata_d;
    end
  end

  assign ack       = ack_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;
  assign m_addr    = m_addr_q;
  assign m_sel     = m_sel_q;
  assign m_enable  = m_enable_q;
  assign m_write   = m_write_q;
  assign m_wdata   = m_wdata_q;

endmodule
